// File: rtl/bp_pkg.sv
// Shared constants and helpers for the branch-prediction training path.
package bp_pkg;

    localparam logic BP_TAKEN     = 1'b1;
    localparam logic BP_NOT_TAKEN = 1'b0;

    localparam int BP_DEPTH = 4;
    localparam int BP_CNT_W = 16;
    localparam int BP_PTR_W = $clog2(BP_DEPTH) + 1;

    // True when the resolved direction disagrees with the stored prediction.
    function automatic logic bp_is_mispredict(input logic predicted, input logic actual);
        return (predicted != actual);
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Increment-enable counter that sticks at its all-ones maximum.
module bp_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_VAL = {W{1'b1}};
    localparam logic [W-1:0] ONE_VAL = {{(W-1){1'b0}}, 1'b1};

    // Count enabled events, holding once the maximum is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= {W{1'b0}};
        end else if (inc && (count != MAX_VAL)) begin
            count <= count + ONE_VAL;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of issued predictions; on resolve it trains the predictor,
// flags mispredicts, squashes wrong-path entries and keeps accuracy counts.
module branch_resolve_queue
    import bp_pkg::*;
#(
    parameter int DEPTH = BP_DEPTH,
    parameter int CNT_W = BP_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pred_valid,
    input  logic                     pred_taken,
    output logic                     pred_ready,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    output logic                     upd_result,
    output logic                     upd_taken,
    output logic                     mispredict,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         resolved_cnt,
    output logic [CNT_W-1:0]         mispred_cnt,
    output logic                     err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [DEPTH-1:0] mem_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] occ_r;
    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic             mis_s;
    logic             entry_s;
    logic             upd_result_r;
    logic             upd_taken_r;
    logic             mispredict_r;
    logic             err_r;

    assign full_s  = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                     (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]);
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign push_s  = pred_valid && !full_s;
    assign pop_s   = resolve_valid && !empty_s;
    assign entry_s = mem_r[rd_ptr_r[IDX_W-1:0]];
    assign mis_s   = pop_s && bp_is_mispredict(entry_s, resolve_taken);

    // Next pointers: a mispredict collapses the queue behind the popped entry.
    always_comb begin
        rd_ptr_nxt_s = rd_ptr_r;
        wr_ptr_nxt_s = wr_ptr_r;
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        if (mis_s) begin
            wr_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
    end

    // Pointer, occupancy and sticky error state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            occ_r    <= {PTR_W{1'b0}};
            err_r    <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            occ_r    <= wr_ptr_nxt_s - rd_ptr_nxt_s;
            err_r    <= err_r | (pred_valid && full_s) | (resolve_valid && empty_s);
        end
    end

    // Prediction storage; a push racing a flush is wrong-path and not kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r <= {DEPTH{1'b0}};
        end else if (push_s && !mis_s) begin
            mem_r[wr_ptr_r[IDX_W-1:0]] <= pred_taken;
        end else begin
            mem_r <= mem_r;
        end
    end

    // Training outputs, one cycle after the resolving edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_result_r <= 1'b0;
            upd_taken_r  <= BP_NOT_TAKEN;
            mispredict_r <= 1'b0;
        end else begin
            upd_result_r <= pop_s;
            upd_taken_r  <= pop_s ? resolve_taken : upd_taken_r;
            mispredict_r <= mis_s;
        end
    end

    bp_sat_counter #(.W(CNT_W)) u_resolved_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pop_s),
        .count (resolved_cnt)
    );

    bp_sat_counter #(.W(CNT_W)) u_mispred_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mis_s),
        .count (mispred_cnt)
    );

    assign pred_ready = !full_s;
    assign occupancy  = occ_r;
    assign upd_result = upd_result_r;
    assign upd_taken  = upd_taken_r;
    assign mispredict = mispredict_r;
    assign err        = err_r;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench: stimulus queues expected training responses, a negedge
// monitor pops and compares them whenever the queue presents an update.
module tb_branch_resolve_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             pred_valid;
    logic             pred_taken;
    logic             pred_ready;
    logic             resolve_valid;
    logic             resolve_taken;
    logic             upd_result;
    logic             upd_taken;
    logic             mispredict;
    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] resolved_cnt;
    logic [CNT_W-1:0] mispred_cnt;
    logic             err;

    typedef struct {
        logic taken;
        logic mis;
        int   due;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;

    branch_resolve_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pred_valid    (pred_valid),
        .pred_taken    (pred_taken),
        .pred_ready    (pred_ready),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .upd_result    (upd_result),
        .upd_taken     (upd_taken),
        .mispredict    (mispredict),
        .occupancy     (occupancy),
        .resolved_cnt  (resolved_cnt),
        .mispred_cnt   (mispred_cnt),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every presented update against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (upd_result) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_upd", 32'd1, 32'd0);
                end else begin
                    chk("upd_taken", {31'd0, upd_taken}, {31'd0, exp_q[0].taken});
                    chk("mispredict", {31'd0, mispredict}, {31'd0, exp_q[0].mis});
                    chk("upd_latency", cyc, exp_q[0].due);
                    void'(exp_q.pop_front());
                end
            end else begin
                chk("no_mispredict_idle", {31'd0, mispredict}, 32'd0);
                if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                    chk("missing_upd", 32'd0, 32'd1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Apply one cycle of stimulus; expect is queued only when a pop should occur.
    task automatic drive(input logic pv, input logic pt, input logic rv, input logic rt,
                         input logic exp_pop, input logic exp_mis);
        exp_t e;
        pred_valid    = pv;
        pred_taken    = pt;
        resolve_valid = rv;
        resolve_taken = rt;
        if (exp_pop) begin
            e.taken = rt;
            e.mis   = exp_mis;
            e.due   = cyc + 1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        pred_valid    = 1'b0;
        resolve_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        pred_valid    = 1'b0;
        pred_taken    = 1'b0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        do_reset();

        // Idle after reset.
        repeat (5) @(posedge clk);
        #1;
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_ready", {31'd0, pred_ready}, 32'd1);
        chk("rst_upd_result", {31'd0, upd_result}, 32'd0);
        chk("rst_upd_taken", {31'd0, upd_taken}, 32'd0);
        chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
        chk("rst_resolved", 32'(resolved_cnt), 32'd0);
        chk("rst_mispred", 32'(mispred_cnt), 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);

        // Fill T,T,N,T then overflow.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("full_occ", 32'(occupancy), 32'd4);
        chk("full_ready", {31'd0, pred_ready}, 32'd0);
        chk("pre_ovf_err", {31'd0, err}, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovf_err", {31'd0, err}, 32'd1);
        chk("ovf_occ", 32'(occupancy), 32'd4);

        // Drain with all-correct resolves.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("drain_resolved", 32'(resolved_cnt), 32'd4);
        chk("drain_mispred", 32'(mispred_cnt), 32'd0);
        chk("drain_occ", 32'(occupancy), 32'd0);
        chk("drain_ready", {31'd0, pred_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Clean slate so the flush phase can show err staying low.
        do_reset();
        chk("rst2_err", {31'd0, err}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_flush_occ", 32'(occupancy), 32'd3);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_mispred", 32'(mispred_cnt), 32'd1);
        chk("flush_resolved", 32'(resolved_cnt), 32'd1);
        chk("flush_err", {31'd0, err}, 32'd0);
        chk("flush_upd_taken", {31'd0, upd_taken}, 32'd0);
        // Queue keeps working after the flush.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_flush_occ", 32'(occupancy), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("post_flush_drain", 32'(occupancy), 32'd0);

        // Underflow cases.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("udf_err", {31'd0, err}, 32'd1);
        chk("udf_upd_result", {31'd0, upd_result}, 32'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("push_udf_occ", 32'(occupancy), 32'd1);
        chk("push_udf_upd_result", {31'd0, upd_result}, 32'd0);
        chk("push_udf_resolved", 32'(resolved_cnt), 32'd2);

        // 16 more correct pops, 15 of them overlapped with pushes; counter saturates.
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            chk("overlap_occ", 32'(occupancy), 32'd1);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("sat_resolved", 32'(resolved_cnt), 32'd15);
        chk("sat_mispred", 32'(mispred_cnt), 32'd1);
        chk("sat_occ", 32'(occupancy), 32'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset between clock edges.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_async_occ", 32'(occupancy), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_occ", 32'(occupancy), 32'd0);
        chk("async_resolved", 32'(resolved_cnt), 32'd0);
        chk("async_mispred", 32'(mispred_cnt), 32'd0);
        chk("async_err", {31'd0, err}, 32'd0);
        chk("async_ready", {31'd0, pred_ready}, 32'd1);
        chk("async_upd_taken", {31'd0, upd_taken}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
